// File: rtl/demux7_deserializer_pkg.sv
// Shared types and defaults for the 7-slot serial-to-parallel deserialiser.
package demux7_deserializer_pkg;
  localparam int WIDTH_DEF = 7;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;
endpackage

// File: rtl/demux7_deserializer_if.sv
// Serial input and parallel output handshake bundle of the deserialiser.
// A transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface demux7_deserializer_if #(
  parameter int WIDTH = 7
) ();
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output in_bit, in_valid, word_ready,
    input  in_ready, word_out, word_valid
  );

  modport slave (
    input  in_bit, in_valid, word_ready,
    output in_ready, word_out, word_valid
  );
endinterface

// File: rtl/demux7_deserializer_slot_counter.sv
// Mod-WIDTH slot index with enable and synchronous clear.
module demux7_deserializer_slot_counter #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/demux7_deserializer.sv
// Steers accepted serial bits into slots 0..WIDTH-1 and presents the word,
// with a shadow register that lets the next word fill while the output waits.
module demux7_deserializer
  import demux7_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         clear,
  demux7_deserializer_if.slave         bus,
  output logic [CNT_W-1:0]             slot,
  output state_t                       state
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_d;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word_q;
  logic             valid_q;
  logic             accept;
  logic             complete;
  logic             out_free;

  assign accept   = bus.in_valid && (state == FILL);
  assign complete = accept && (slot == LAST);
  assign out_free = !valid_q || bus.word_ready;

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;

  demux7_deserializer_slot_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .en     (accept),
    .count  (slot)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FILL;
    end else if (clear) begin
      state <= FILL;
    end else begin
      state <= state_d;
    end
  end

  // in_ready is a pure state decode so the consumer never reaches the source combinationally.
  always_comb begin
    state_d      = state;
    bus.in_ready = 1'b0;
    case (state)
      FILL: begin
        bus.in_ready = 1'b1;
        if (complete && !out_free) state_d = STALL;
      end
      STALL: begin
        if (bus.word_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      shadow  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (state == FILL) begin
      if (accept && !complete) begin
        shadow[slot] <= bus.in_bit;
      end
      if (complete && out_free) begin
        word_q  <= {bus.in_bit, shadow[WIDTH-2:0]};
        valid_q <= 1'b1;
      end else if (complete) begin
        shadow[WIDTH-1] <= bus.in_bit;
      end else if (valid_q && bus.word_ready) begin
        valid_q <= 1'b0;
      end
    end else if (bus.word_ready) begin
      // Stalled word moves out as the old one is consumed; valid stays high.
      word_q <= shadow;
    end
  end
endmodule

// File: tb/tb_demux7_deserializer.sv
// Directed table-driven bench for demux7_deserializer plus clear and async-reset sequences.
module tb_demux7_deserializer;
  import demux7_deserializer_pkg::*;

  localparam int WIDTH = 7;
  localparam int CNT_W = 3;

  logic             clock;
  logic             resetn;
  logic             clear;
  logic [CNT_W-1:0] slot;
  state_t           state;

  demux7_deserializer_if #(.WIDTH(WIDTH)) bus ();

  demux7_deserializer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus),
    .slot   (slot),
    .state  (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             in_bit;
    logic             in_valid;
    logic             word_ready;
    logic             clr;
    logic [WIDTH-1:0] exp_word;
    logic             exp_valid;
    logic [CNT_W-1:0] exp_slot;
    logic             exp_ready;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] w, input logic wv,
                               input logic [CNT_W-1:0] s, input logic rdy);
    check({tag, " word_out"},   32'(bus.word_out),   32'(w));
    check({tag, " word_valid"}, 32'(bus.word_valid), 32'(wv));
    check({tag, " slot"},       32'(slot),           32'(s));
    check({tag, " in_ready"},   32'(bus.in_ready),   32'(rdy));
  endtask

  // Called at a negedge: drive inputs, take one rising edge, return at the next negedge.
  task automatic step(input logic b, input logic v, input logic r, input logic c);
    bus.in_bit     = b;
    bus.in_valid   = v;
    bus.word_ready = r;
    clear          = c;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic add(input logic b, input logic v, input logic r, input logic c,
                     input logic [WIDTH-1:0] w, input logic wv, input logic [CNT_W-1:0] s,
                     input logic rdy);
    vec_t e;
    e.in_bit = b; e.in_valid = v; e.word_ready = r; e.clr = c;
    e.exp_word = w; e.exp_valid = wv; e.exp_slot = s; e.exp_ready = rdy;
    vecs.push_back(e);
  endtask

  initial begin
    logic [WIDTH-1:0] bits;

    resetn = 1'b0;
    clear = 1'b0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs("reset", 7'b0, 1'b0, 3'd0, 1'b1);
    check("reset state", 32'(state), 32'(FILL));
    resetn = 1'b1;
    @(negedge clock);

    // First word 1,0,1,1,0,0,1 with consumer stalled.
    add(1, 1, 0, 0, 7'b0000000, 0, 3'd1, 1);
    add(0, 1, 0, 0, 7'b0000000, 0, 3'd2, 1);
    add(1, 1, 0, 0, 7'b0000000, 0, 3'd3, 1);
    add(1, 1, 0, 0, 7'b0000000, 0, 3'd4, 1);
    add(0, 1, 0, 0, 7'b0000000, 0, 3'd5, 1);
    add(0, 1, 0, 0, 7'b0000000, 0, 3'd6, 1);
    add(1, 1, 0, 0, 7'b1001101, 1, 3'd0, 1);
    // Second word of ones fills the shadow, then stalls.
    for (int i = 1; i <= 6; i++) add(1, 1, 0, 0, 7'b1001101, 1, CNT_W'(i), 1);
    add(1, 1, 0, 0, 7'b1001101, 1, 3'd0, 0);
    add(0, 1, 0, 0, 7'b1001101, 1, 3'd0, 0);
    add(0, 0, 1, 0, 7'b1111111, 1, 3'd0, 1);
    add(1, 0, 0, 0, 7'b1111111, 1, 3'd0, 1);
    // Word 0,1,1,0,0,1,0; consume lands on the completing edge.
    add(0, 1, 0, 0, 7'b1111111, 1, 3'd1, 1);
    add(1, 1, 0, 0, 7'b1111111, 1, 3'd2, 1);
    add(1, 1, 0, 0, 7'b1111111, 1, 3'd3, 1);
    add(0, 1, 0, 0, 7'b1111111, 1, 3'd4, 1);
    add(0, 1, 0, 0, 7'b1111111, 1, 3'd5, 1);
    add(1, 1, 0, 0, 7'b1111111, 1, 3'd6, 1);
    add(0, 1, 1, 0, 7'b0100110, 1, 3'd0, 1);
    // Bubbled word 0,1,0,1,0,1,0; bubble bits carry junk.
    add(0, 1, 1, 0, 7'b0100110, 0, 3'd1, 1);
    add(1, 0, 1, 0, 7'b0100110, 0, 3'd1, 1);
    add(0, 0, 1, 0, 7'b0100110, 0, 3'd1, 1);
    add(1, 1, 1, 0, 7'b0100110, 0, 3'd2, 1);
    add(1, 0, 1, 0, 7'b0100110, 0, 3'd2, 1);
    add(0, 1, 1, 0, 7'b0100110, 0, 3'd3, 1);
    add(1, 1, 1, 0, 7'b0100110, 0, 3'd4, 1);
    add(1, 0, 1, 0, 7'b0100110, 0, 3'd4, 1);
    add(0, 1, 1, 0, 7'b0100110, 0, 3'd5, 1);
    add(1, 1, 1, 0, 7'b0100110, 0, 3'd6, 1);
    add(1, 0, 1, 0, 7'b0100110, 0, 3'd6, 1);
    add(0, 1, 1, 0, 7'b0101010, 1, 3'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in_bit, vecs[i].in_valid, vecs[i].word_ready, vecs[i].clr);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_valid,
                    vecs[i].exp_slot, vecs[i].exp_ready);
    end

    // Clear mid-word; the accept and consume in the clear cycle are ignored.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    check("pre-clear slot", 32'(slot), 32'd4);
    step(1, 1, 1, 1);
    check_outputs("clear", 7'b0, 1'b0, 3'd0, 1'b1);
    bits = 7'b1000000;
    for (int i = 0; i < WIDTH; i++) step(bits[i], 1, 0, 0);
    check_outputs("post-clear word", 7'b1000000, 1'b1, 3'd0, 1'b1);

    // Drive into STALL, then reset asynchronously between edges.
    bits = 7'b0110011;
    for (int i = 0; i < WIDTH; i++) step(bits[i], 1, 0, 0);
    check_outputs("stall again", 7'b1000000, 1'b1, 3'd0, 1'b0);
    check("stall state", 32'(state), 32'(STALL));
    #2 resetn = 1'b0;
    #1;
    check_outputs("async reset", 7'b0, 1'b0, 3'd0, 1'b1);
    check("async reset state", 32'(state), 32'(FILL));
    @(negedge clock);
    resetn = 1'b1;
    bits = 7'b0000001;
    for (int i = 0; i < WIDTH; i++) step(bits[i], 1, 0, 0);
    check_outputs("post-reset word", 7'b0000001, 1'b1, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
